mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one single-port memory bus between instruction fetch (read-only) and the execute stage's data-memory port (load/store with width).
Grants one transaction at a time, with data priority and a fetch anti-starvation counter.
Performs store byte-lane steering, rejects misaligned accesses, and aborts stalled bus transactions on timeout.
Sits between the fetch/execute stages and the memory/peripheral bus.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while fetch is waiting before fetch is forced to win; 0 = strict data priority.
TIMEOUT_CYCLES, 255, bus cycles to wait for bus_ack_i before aborting with error; 0 = never time out.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
if_req_i  in  1  fetch request; held with if_addr_i until if_ready_o
if_addr_i  in  32  fetch address, word aligned (bits [1:0] ignored)
if_ready_o  out  1  one-cycle accept pulse for fetch
if_rvalid_o  out  1  one-cycle response pulse
if_rdata_o  out  32  fetched word
if_err_o  out  1  response is error (timeout); valid with if_rvalid_o
dm_req_i  in  1  data request; held with payload until dm_ready_o
dm_addr_i  in  32  byte address
dm_wdata_i  in  32  store data, right-justified
dm_write_i  in  1  1 = store, 0 = load
dm_width_i  in  2  00 byte, 01 half, 10 word, 11 illegal
dm_ready_o  out  1  one-cycle accept pulse for data
dm_rvalid_o  out  1  one-cycle completion pulse (loads and stores)
dm_rdata_o  out  32  raw bus word (loads); 0 for stores and errors
dm_err_o  out  1  misaligned, illegal width, or timeout; valid with dm_rvalid_o
bus_req_o  out  1  bus request, held until ack or abort
bus_addr_o  out  32  word address ({addr[31:2],2'b00})
bus_we_o  out  1  write enable
bus_wstrb_o  out  4  byte strobes; 0000 on reads
bus_wdata_o  out  32  lane-steered write data
bus_ack_i  in  1  bus completion; bus_rdata_i valid in the same cycle
bus_rdata_i  in  32  read data

Behaviour:
- Reset: all outputs 0, state IDLE, starve_cnt 0, timeout counter 0. Reset mid-transaction: bus_req_o drops at that edge; a later bus_ack_i is ignored; no rvalid is issued for the aborted transaction.
- FSM states:
  - IDLE: arbitrates and asserts the winner's *_ready_o combinationally in the same cycle. Payload is latched at the edge.
  - BUS_IF / BUS_DM: bus_req_o is registered high from the next cycle until bus_ack_i, or until timeout.
  - Exit BUS_IF / BUS_DM on ack or timeout to IDLE. *_rvalid_o/rdata/err are registered and pulse in the cycle after the ack/timeout edge.
- Arbitration (IDLE only):
  - dm wins, unless if_req_i is set and STARVE_LIMIT != 0 and starve_cnt == STARVE_LIMIT; then if wins.
  - starve_cnt increments on each dm grant while if_req_i is high, and saturates at STARVE_LIMIT.
  - starve_cnt clears on an if grant, or on a dm grant while if_req_i is low.
- Latency: request in IDLE at cycle N -> ready at N; bus_req_o at N+1; ack at N+k (k>=1) -> rvalid at N+k+1; next grant possible at N+k+1. At most one outstanding transaction; *_ready_o is never asserted outside IDLE.
- Store steering:
  - byte: strobe 0001<<addr[1:0], data {4{wdata[7:0]}}.
  - half: strobe 0011<<{addr[1],1'b0}, data {2{wdata[15:0]}}.
  - word: strobe 1111, data wdata.
- Loads: bus_we_o=0, strobe 0000; dm_rdata_o is the unshifted bus word.
- Illegal dm request (width 11, half with addr[0]=1, word with addr[1:0]!=0):
  - Still accepted (dm_ready_o pulses) and still counts as a dm grant for the starvation logic.
  - No bus cycle; state stays IDLE.
  - dm_rvalid_o=1, dm_err_o=1, dm_rdata_o=0 next cycle.
- Timeout: the counter counts bus_req_o cycles without ack. When it reaches TIMEOUT_CYCLES, the FSM deasserts bus_req_o, returns to IDLE, and issues rvalid with err=1 and rdata=0. If the ack coincides with the final count, the ack wins (normal completion).
- Acks while bus_req_o is low are ignored.

Decomposition:
- Shared include memarb_def.v holds:
  - width codes (MEM_W_BYTE/HALF/WORD)
  - FSM state encodings (ARB_IDLE, ARB_BUS_IF, ARB_BUS_DM)
  - strobe constants
- Sub-module store_align: combinational; addr[1:0], width and wdata in; wstrb, steered wdata and misaligned flag out.

Test Plan:
- Fetch read of 0x100 with bus_ack 2 cycles after bus_req -> if_ready at N, bus_addr 0x100 with we=0, strb 0000; if_rvalid with bus word at ack+1; err=0.
- Store byte 0xA5 to 0x203 -> bus_addr 0x200, strb 1000, wdata 0xA5A5A5A5; dm_rvalid=1 with rdata 0 after ack.
- Half store to 0x101, word load from 0x102, width 11 -> no bus_req; dm_rvalid+dm_err one cycle after each accept.
- if_req and dm_req both held continuously with STARVE_LIMIT=4, ack latency 1 -> grant order D,D,D,D,I,D,D,D,D,I.
- TIMEOUT_CYCLES=8, never ack -> bus_req high for exactly 8 cycles then drops; rvalid+err next cycle; a late ack is ignored.
- rst asserted with bus_req high -> bus_req 0 after the edge; no rvalid; the next request is served normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Width codes, FSM states and strobe constants for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    localparam logic [1:0] MEM_W_BYTE = 2'b00;
    localparam logic [1:0] MEM_W_HALF = 2'b01;
    localparam logic [1:0] MEM_W_WORD = 2'b10;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUS_IF = 2'd1,
        ARB_BUS_DM = 2'd2
    } arb_state_e;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_store_align.sv
// ============================================================================
// Module      : mem_arbiter_store_align
// Description : Store byte-lane steering and alignment check (combinational).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter_store_align
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_width,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic        o_misaligned
);

    always_comb begin
        o_wstrb      = STRB_NONE;
        o_wdata      = '0;
        o_misaligned = 1'b0;
        case (i_width)
            MEM_W_BYTE: begin
                o_wstrb = STRB_BYTE << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            MEM_W_HALF: begin
                o_wstrb      = STRB_HALF << {i_addr_lo[1], 1'b0};
                o_wdata      = {2{i_wdata[15:0]}};
                o_misaligned = i_addr_lo[0];
            end
            MEM_W_WORD: begin
                o_wstrb      = STRB_WORD;
                o_wdata      = i_wdata;
                o_misaligned = |i_addr_lo;
            end
            // Width code 11 is illegal and treated like a misaligned access
            default: o_misaligned = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Fetch/data arbiter onto one memory bus with anti-starvation,
//               store lane steering, misalignment rejection and bus timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ready_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    output logic        if_err_o,
    input  logic        dm_req_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    input  logic        dm_write_i,
    input  logic [1:0]  dm_width_i,
    output logic        dm_ready_o,
    output logic        dm_rvalid_o,
    output logic [31:0] dm_rdata_o,
    output logic        dm_err_o,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_wstrb_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] c_starve_max = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] c_tmo_last   = TW'(TIMEOUT_CYCLES - 1);
    localparam bit            c_starve_en  = (STARVE_LIMIT != 0);
    localparam bit            c_tmo_en     = (TIMEOUT_CYCLES != 0);

    arb_state_e    r_state;
    arb_state_e    w_state_nxt;
    logic [SW-1:0] r_starve_cnt;
    logic [TW-1:0] r_tmo_cnt;

    logic          r_bus_req;
    logic [31:0]   r_bus_addr;
    logic          r_bus_we;
    logic [3:0]    r_bus_wstrb;
    logic [31:0]   r_bus_wdata;
    logic          r_if_rvalid;
    logic [31:0]   r_if_rdata;
    logic          r_if_err;
    logic          r_dm_rvalid;
    logic [31:0]   r_dm_rdata;
    logic          r_dm_err;

    logic          w_idle;
    logic          w_if_wins;
    logic          w_grant_if;
    logic          w_grant_dm;
    logic          w_dm_bad;
    logic          w_bus_ack;
    logic          w_bus_tmo;
    logic          w_bus_end;
    logic [3:0]    w_strb;
    logic [31:0]   w_wdata;

    mem_arbiter_store_align u_store_align (
        .i_addr_lo    (dm_addr_i[1:0]),
        .i_width      (dm_width_i),
        .i_wdata      (dm_wdata_i),
        .o_wstrb      (w_strb),
        .o_wdata      (w_wdata),
        .o_misaligned (w_dm_bad)
    );

    // Ready is combinational in IDLE; reset masks it so all outputs read 0
    assign w_idle     = (r_state == ARB_IDLE) && !rst;
    assign w_if_wins  = if_req_i &&
                        (!dm_req_i || (c_starve_en && (r_starve_cnt == c_starve_max)));
    assign w_grant_if = w_idle && w_if_wins;
    assign w_grant_dm = w_idle && dm_req_i && !w_if_wins;

    // Ack takes precedence over a timeout landing in the same cycle
    assign w_bus_ack  = r_bus_req && bus_ack_i;
    assign w_bus_tmo  = r_bus_req && !bus_ack_i && c_tmo_en && (r_tmo_cnt == c_tmo_last);
    assign w_bus_end  = w_bus_ack || w_bus_tmo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_grant_if) begin
                    w_state_nxt = ARB_BUS_IF;
                end else if (w_grant_dm && !w_dm_bad) begin
                    w_state_nxt = ARB_BUS_DM;
                end
            end
            ARB_BUS_IF, ARB_BUS_DM: begin
                if (w_bus_end) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_req   <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_we    <= 1'b0;
            r_bus_wstrb <= STRB_NONE;
            r_bus_wdata <= '0;
            r_tmo_cnt   <= '0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_if_err    <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_dm_rdata  <= '0;
            r_dm_err    <= 1'b0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_if_err    <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_dm_rdata  <= '0;
            r_dm_err    <= 1'b0;

            if (w_grant_if) begin
                r_bus_req   <= 1'b1;
                r_bus_addr  <= word_addr(if_addr_i);
                r_bus_we    <= 1'b0;
                r_bus_wstrb <= STRB_NONE;
                r_bus_wdata <= '0;
                r_tmo_cnt   <= '0;
            end else if (w_grant_dm) begin
                if (w_dm_bad) begin
                    r_dm_rvalid <= 1'b1;
                    r_dm_err    <= 1'b1;
                end else begin
                    r_bus_req   <= 1'b1;
                    r_bus_addr  <= word_addr(dm_addr_i);
                    r_bus_we    <= dm_write_i;
                    r_bus_wstrb <= dm_write_i ? w_strb : STRB_NONE;
                    r_bus_wdata <= dm_write_i ? w_wdata : '0;
                    r_tmo_cnt   <= '0;
                end
            end

            if (w_bus_end) begin
                r_bus_req <= 1'b0;
                r_tmo_cnt <= '0;
                if (r_state == ARB_BUS_IF) begin
                    r_if_rvalid <= 1'b1;
                    r_if_err    <= w_bus_tmo;
                    r_if_rdata  <= w_bus_ack ? bus_rdata_i : '0;
                end else begin
                    r_dm_rvalid <= 1'b1;
                    r_dm_err    <= w_bus_tmo;
                    r_dm_rdata  <= (w_bus_ack && !r_bus_we) ? bus_rdata_i : '0;
                end
            end else if (r_bus_req) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

    // Rejected (misaligned) data requests still count as data grants here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_grant_if) begin
            r_starve_cnt <= '0;
        end else if (w_grant_dm) begin
            if (!if_req_i) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != c_starve_max) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    assign if_ready_o  = w_grant_if;
    assign dm_ready_o  = w_grant_dm;
    assign if_rvalid_o = r_if_rvalid;
    assign if_rdata_o  = r_if_rdata;
    assign if_err_o    = r_if_err;
    assign dm_rvalid_o = r_dm_rvalid;
    assign dm_rdata_o  = r_dm_rdata;
    assign dm_err_o    = r_dm_err;
    assign bus_req_o   = r_bus_req;
    assign bus_addr_o  = r_bus_addr;
    assign bus_we_o    = r_bus_we;
    assign bus_wstrb_o = r_bus_wstrb;
    assign bus_wdata_o = r_bus_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int SL = 4;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready_o, if_rvalid_o, if_err_o;
    logic [31:0] if_rdata_o;
    logic        dm_req;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_write;
    logic [1:0]  dm_width;
    logic        dm_ready_o, dm_rvalid_o, dm_err_o;
    logic [31:0] dm_rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_wstrb_o;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    mem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ready_o(if_ready_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
        .dm_req_i(dm_req), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_write_i(dm_write), .dm_width_i(dm_width), .dm_ready_o(dm_ready_o),
        .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o), .dm_err_o(dm_err_o),
        .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o),
        .bus_wstrb_o(bus_wstrb_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata)
    );

    always #5 clk = ~clk;

    int    n_pass    = 0;
    int    n_total   = 0;
    int    m_starve  = 0;
    string grant_log = "";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_bad(input logic [31:0] a, input logic [1:0] w);
        return (w == 2'd3) || (w == 2'd1 && (a % 2) != 0) || (w == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic [3:0] ref_strb(input logic [31:0] a, input logic [1:0] w);
        if (w == 2'd0) return 4'(1 << (a % 4));
        if (w == 2'd1) return 4'(3 << (a % 4));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_data(input logic [31:0] d, input logic [1:0] w);
        if (w == 2'd0) return 32'(d % 256) * 32'h0101_0101;
        if (w == 2'd1) return 32'(d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    // One arbitration decision starting in an IDLE cycle, plus the full bus
    // phase; ack_lat = bus_req cycle carrying the ack (0 = never ack).
    task automatic arb_step(input int ack_lat, input bit hold);
        bit          g_if, g_dm, bad, wr, timed_out;
        logic [31:0] a, rd, exp_rd, exp_wd;
        logic [3:0]  exp_sb;
        int          ncyc;
        g_if = if_req && (!dm_req || (SL != 0 && m_starve == SL));
        g_dm = dm_req && !g_if;
        #1;
        chk("if_ready", 32'(if_ready_o), 32'(g_if));
        chk("dm_ready", 32'(dm_ready_o), 32'(g_dm));
        if (g_if) grant_log = {grant_log, "I"};
        else if (g_dm) grant_log = {grant_log, "D"};
        if (g_if) m_starve = 0;
        else if (g_dm) m_starve = if_req ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
        a      = g_if ? if_addr : dm_addr;
        bad    = g_dm && is_bad(dm_addr, dm_width);
        wr     = g_dm && dm_write;
        exp_sb = wr ? ref_strb(dm_addr, dm_width) : 4'h0;
        exp_wd = ref_data(dm_wdata, dm_width);
        rd     = $urandom;
        tick();
        if (!hold) begin
            if (g_if) if_req = 1'b0;
            if (g_dm) dm_req = 1'b0;
        end
        if (!g_if && !g_dm) begin
            chk("idle_bus_req", 32'(bus_req_o), 32'd0);
            return;
        end
        if (bad) begin
            chk("bad_bus_req", 32'(bus_req_o), 32'd0);
            chk("bad_rvalid", 32'(dm_rvalid_o), 32'd1);
            chk("bad_err", 32'(dm_err_o), 32'd1);
            chk("bad_rdata", dm_rdata_o, 32'd0);
            return;
        end
        timed_out = 1'b0;
        ncyc      = 0;
        for (int c = 1; c <= TO; c++) begin
            chk("bus_req_high", 32'(bus_req_o), 32'd1);
            if (c == 1) begin
                chk("bus_addr", bus_addr_o, a - (a % 4));
                chk("bus_we", 32'(bus_we_o), 32'(wr));
                chk("bus_wstrb", 32'(bus_wstrb_o), 32'(exp_sb));
                if (wr) chk("bus_wdata", bus_wdata_o, exp_wd);
                chk("early_rvalid", 32'(if_rvalid_o | dm_rvalid_o), 32'd0);
            end
            bus_ack   = (c == ack_lat);
            bus_rdata = rd;
            timed_out = (c == TO) && (c != ack_lat);
            ncyc      = c;
            tick();
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
            if (c == ack_lat || timed_out) break;
        end
        exp_rd = (timed_out || wr) ? 32'd0 : rd;
        chk("bus_req_drop", 32'(bus_req_o), 32'd0);
        if (timed_out) chk("timeout_len", 32'(ncyc), 32'(TO));
        chk(g_if ? "if_rvalid" : "dm_rvalid", 32'(g_if ? if_rvalid_o : dm_rvalid_o), 32'd1);
        chk("other_rvalid", 32'(g_if ? dm_rvalid_o : if_rvalid_o), 32'd0);
        chk(g_if ? "if_err" : "dm_err", 32'(g_if ? if_err_o : dm_err_o), 32'(timed_out));
        chk(g_if ? "if_rdata" : "dm_rdata", g_if ? if_rdata_o : dm_rdata_o, exp_rd);
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h0; dm_req = 1'b1; dm_addr = 32'h0;
        dm_wdata = 32'h0; dm_write = 1'b0; dm_width = 2'd2; bus_ack = 1'b0; bus_rdata = 32'h0;
        tick(); tick();
        chk("rst_if_ready", 32'(if_ready_o), 32'd0);
        chk("rst_dm_ready", 32'(dm_ready_o), 32'd0);
        chk("rst_bus_req", 32'(bus_req_o), 32'd0);
        chk("rst_rvalid", 32'(if_rvalid_o | dm_rvalid_o), 32'd0);
        if_req = 1'b0; dm_req = 1'b0;
        rst = 1'b0;
        tick();

        // Fetch from 0x100, ack two cycles after bus_req rises
        if_req = 1'b1; if_addr = 32'h100;
        arb_step(3, 1'b0);

        // Byte store 0xA5 to 0x203
        dm_req = 1'b1; dm_addr = 32'h203; dm_wdata = 32'hA5; dm_write = 1'b1; dm_width = 2'd0;
        arb_step(2, 1'b0);

        // Rejected accesses: misaligned half, misaligned word, illegal width
        dm_req = 1'b1; dm_addr = 32'h101; dm_write = 1'b1; dm_width = 2'd1;
        arb_step(1, 1'b0);
        dm_req = 1'b1; dm_addr = 32'h102; dm_write = 1'b0; dm_width = 2'd2;
        arb_step(1, 1'b0);
        dm_req = 1'b1; dm_addr = 32'h100; dm_write = 1'b0; dm_width = 2'd3;
        arb_step(1, 1'b0);

        // Both requesters held continuously
        grant_log = "";
        if_req = 1'b1; if_addr = 32'h500;
        dm_req = 1'b1; dm_addr = 32'h400; dm_write = 1'b0; dm_width = 2'd2;
        for (int i = 0; i < 10; i++) arb_step(1, 1'b1);
        if_req = 1'b0; dm_req = 1'b0;
        n_total++;
        assert (grant_log == "DDDDIDDDDI") n_pass++;
        else $error("FAIL grant_order: observed %s expected DDDDIDDDDI", grant_log);

        // Timeout on a fetch, then a late ack must be ignored
        tick();
        if_req = 1'b1; if_addr = 32'h600;
        arb_step(0, 1'b0);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("late_ack_rvalid", 32'(if_rvalid_o | dm_rvalid_o), 32'd0);
        chk("late_ack_bus_req", 32'(bus_req_o), 32'd0);

        // Ack on the final timeout count completes normally
        dm_req = 1'b1; dm_addr = 32'h700; dm_write = 1'b0; dm_width = 2'd2;
        arb_step(TO, 1'b0);

        // Reset in the middle of a bus transaction
        if_req = 1'b1; if_addr = 32'h300;
        #1;
        chk("pre_rst_if_ready", 32'(if_ready_o), 32'd1);
        tick();
        if_req = 1'b0;
        chk("pre_rst_bus_req", 32'(bus_req_o), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_bus_req", 32'(bus_req_o), 32'd0);
        rst = 1'b0; m_starve = 0;
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("post_rst_rvalid", 32'(if_rvalid_o | dm_rvalid_o), 32'd0);
        tick();
        chk("post_rst_rvalid2", 32'(if_rvalid_o | dm_rvalid_o), 32'd0);
        if_req = 1'b1; if_addr = 32'h304;
        arb_step(1, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            int lat;
            if (!if_req && $urandom_range(0, 1) == 1) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (!dm_req && $urandom_range(0, 1) == 1) begin
                dm_req   = 1'b1;
                dm_addr  = $urandom;
                dm_wdata = $urandom;
                dm_write = 1'($urandom_range(0, 1));
                dm_width = 2'($urandom_range(0, 3));
            end
            lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
            arb_step(lat, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
